// File: rtl/jtag_2.sv
// Per-tile serial configuration loader for a daisy-chained tile array.
// Every valid bit is forwarded to the next tile one clock later. The memory
// write strobe rises only for the bits inside this tile's frame, and it is
// aligned with data_out so the two can be used together.
module jtag_2 #(
  parameter int unsigned num_of_tiles = 4,
  parameter int unsigned tile_id      = 0,
  parameter int unsigned mem_cycles   = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  input  logic data_valid,
  output logic memory,
  output logic data_out
);

  localparam int unsigned Total = num_of_tiles * mem_cycles;
  localparam int unsigned Lo    = tile_id * mem_cycles;
  localparam int unsigned CntW  = $clog2(Total + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     offset;
  logic            in_window;
  logic            last_bit;

  // The subtraction wraps for indices below Lo, so one unsigned compare
  // covers both ends of the window, Lo <= cnt <= Lo + mem_cycles - 1.
  assign offset    = 32'(cnt_q) - Lo;
  assign in_window = offset < mem_cycles;
  assign last_bit  = cnt_q == CntW'(Total - 1);

  // Load FSM with registered forwarding and write-strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_out <= 1'b0;
      memory   <= 1'b0;
    end else begin
      unique case (state_q)
        // The counter is still 0 in idle, so the first valid bit is bit 0.
        StIdle, StLoad: begin
          if (data_valid) begin
            data_out <= data_in;
            memory   <= in_window;
            cnt_q    <= cnt_q + CntW'(1);
            state_q  <= last_bit ? StDone : StLoad;
          end else begin
            data_out <= 1'b0;
            memory   <= 1'b0;
          end
        end
        // Bits beyond the stream still pass through for longer chains.
        StDone: begin
          data_out <= data_valid & data_in;
          memory   <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= '0;
          data_out <= 1'b0;
          memory   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_2.sv
// Directed bench for jtag_2.
// Instance 0 uses the default parameters. Instances 1 and 2 use a small
// 3-tile by 4-bit chain, acting as tile 1 and as the last tile.
module tb_jtag_2;

  logic       clk;
  logic       rst;
  logic [2:0] din;
  logic [2:0] val;
  logic [2:0] mem;
  logic [2:0] dout;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic din;
    logic valid;
    logic exp_mem;
    logic exp_dout;
  } vec_t;

  vec_t tbl[$];

  jtag_2 u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .data_in    (din[0]),
    .data_valid (val[0]),
    .memory     (mem[0]),
    .data_out   (dout[0])
  );

  jtag_2 #(
    .num_of_tiles (3),
    .tile_id      (1),
    .mem_cycles   (4)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .data_in    (din[1]),
    .data_valid (val[1]),
    .memory     (mem[1]),
    .data_out   (dout[1])
  );

  jtag_2 #(
    .num_of_tiles (3),
    .tile_id      (2),
    .mem_cycles   (4)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .data_in    (din[2]),
    .data_valid (val[2]),
    .memory     (mem[2]),
    .data_out   (dout[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d so far", passed, total);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din = '0;
    val = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle at the falling edge; return just after the rising edge
  task automatic step(input int s, input logic d, input logic v);
    @(negedge clk);
    din[s] = d;
    val[s] = v;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic d, input logic v, input logic m, input logic o);
    vec_t e;
    e.din      = d;
    e.valid    = v;
    e.exp_mem  = m;
    e.exp_dout = o;
    tbl.push_back(e);
  endtask

  // Apply the table to instance s, checking both outputs each cycle and
  // collecting the bits written to memory.
  task automatic run_table(input int s, input string name,
                           output int pulses, output logic [3:0] cap);
    pulses = 0;
    cap    = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(s, tbl[i].din, tbl[i].valid);
      check($sformatf("%s[%0d].memory", name, i), 32'(mem[s]), 32'(tbl[i].exp_mem));
      check($sformatf("%s[%0d].data_out", name, i), 32'(dout[s]), 32'(tbl[i].exp_dout));
      if (mem[s]) begin
        pulses++;
        cap = {cap[2:0], dout[s]};
      end
    end
    @(negedge clk);
    val[s] = 1'b0;
  endtask

  // Stream 0000_1011_1111 for tile 1 of 3, then two bits past the end
  task automatic load_tile1_table();
    tbl.delete();
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int         pulses;
  logic [3:0] cap;
  logic       bit_d;
  int         pulse_total;

  initial begin
    rst = 1'b1;
    din = '0;
    val = '0;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset%0d.memory", s), 32'(mem[s]), 32'd0);
      check($sformatf("reset%0d.data_out", s), 32'(dout[s]), 32'd0);
    end

    // Test 1: defaults, continuous random stream for 5000 cycles
    do_reset();
    pulse_total = 0;
    for (int i = 0; i < 5000; i++) begin
      bit_d = 1'($urandom_range(0, 1));
      step(0, bit_d, 1'b1);
      check($sformatf("t1[%0d].memory", i), 32'(mem[0]), 32'(i < 4096));
      check($sformatf("t1[%0d].data_out", i), 32'(dout[0]), 32'(bit_d));
      if (mem[0]) pulse_total++;
    end
    check("t1.pulse_count", 32'(pulse_total), 32'd4096);
    @(negedge clk);
    val[0] = 1'b0;

    // Test 2: tile 1 of 3, 4-bit frames
    do_reset();
    load_tile1_table();
    run_table(1, "t2", pulses, cap);
    check("t2.pulse_count", 32'(pulses), 32'd4);
    check("t2.capture", 32'(cap), 32'hb);

    // Test 3: valid dropped for 3 cycles at bit 5; counter must hold
    do_reset();
    tbl.delete();
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0, 1'b1);
    run_table(1, "t3", pulses, cap);
    check("t3.pulse_count", 32'(pulses), 32'd4);
    check("t3.capture", 32'(cap), 32'hb);

    // Test 4: asynchronous reset between edges at bit 6, then a clean reload
    do_reset();
    step(1, 1'b0, 1'b1);
    step(1, 1'b0, 1'b1);
    step(1, 1'b0, 1'b1);
    step(1, 1'b0, 1'b1);
    step(1, 1'b1, 1'b1);
    step(1, 1'b0, 1'b1);
    step(1, 1'b1, 1'b1);
    check("t4.bit6.memory", 32'(mem[1]), 32'd1);
    check("t4.bit6.data_out", 32'(dout[1]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t4.async.memory", 32'(mem[1]), 32'd0);
    check("t4.async.data_out", 32'(dout[1]), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    val[1] = 1'b0;
    load_tile1_table();
    run_table(1, "t4r", pulses, cap);
    check("t4.pulse_count", 32'(pulses), 32'd4);
    check("t4.capture", 32'(cap), 32'hb);

    // Test 5: last tile, stream 0000_0000_1101 plus bits past the end
    do_reset();
    tbl.delete();
    for (int i = 0; i < 8; i++) push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    run_table(2, "t5", pulses, cap);
    check("t5.pulse_count", 32'(pulses), 32'd4);
    check("t5.capture", 32'(cap), 32'hd);

    // Test 6: valid held low after reset; data_in toggles but must not pass
    do_reset();
    pulse_total = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'b0);
      if (mem[0] !== 1'b0 || dout[0] !== 1'b0) pulse_total++;
    end
    check("t6.idle_activity", 32'(pulse_total), 32'd0);
    check("t6.memory", 32'(mem[0]), 32'd0);
    check("t6.data_out", 32'(dout[0]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
